// File: rtl/mul_arb_ctrl_pkg.sv
// Shared definitions for the GF(2^163) multiplier sequencer: field width,
// default multiplier latency and the one-hot controller state encoding.
package mul_arb_ctrl_pkg;

   localparam int M           = 163;
   localparam int MUL_LAT_DEF = 3;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'b0001,
      ST_ISSUE   = 4'b0010,
      ST_WAIT    = 4'b0100,
      ST_CAPTURE = 4'b1000
   } state_t;

endpackage

// File: rtl/mul_arb_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: grants at most one valid requester while free,
// and moves the pointer past the winner only when a grant is issued.
module rr_arb2
   import mul_arb_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       free,
   output logic [1:0] grant
);

   logic       ptr_r;
   logic [1:0] grant_s;

   // grant selection: a lone requester always wins, a tie goes to ptr_r
   always_comb begin
      grant_s = 2'b00;
      if (free) begin
         if (valid == 2'b11) begin
            grant_s = ptr_r ? 2'b10 : 2'b01;
         end else begin
            grant_s = valid;
         end
      end else begin
         grant_s = 2'b00;
      end
   end

   // pointer register: after granting requester 0 favour 1, and vice versa
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= 1'b0;
      end else if (grant_s != 2'b00) begin
         ptr_r <= grant_s[0];
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign grant = grant_s;

endmodule

// File: rtl/mul_arb_ctrl.sv
// Arbitrates two requesters onto the shared field multiplier, issues a one-cycle
// enable with registered operands, waits out its latency and returns the product.
module mul_arb_ctrl
   import mul_arb_ctrl_pkg::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEF
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [M-1:0] req0_a,
   input  logic [M-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [M-1:0] req1_a,
   input  logic [M-1:0] req1_b,
   output logic         rsp0_valid,
   output logic         rsp1_valid,
   output logic [M-1:0] rsp_data,
   output logic         mul_enable,
   output logic [M-1:0] mul_a,
   output logic [M-1:0] mul_b,
   input  logic [M-1:0] mul_result,
   output logic         busy
);

   localparam int             CW       = $clog2(MUL_LAT + 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_INIT = CW'(MUL_LAT - 1);

   state_t        state_r, next_state_s;
   logic [CW-1:0] cnt_r;
   logic          owner_r;
   logic [1:0]    grant_s;
   logic          free_s, accept_s;
   logic [M-1:0]  mul_a_r, mul_b_r, rsp_data_r;
   logic          mul_enable_r, rsp0_valid_r, rsp1_valid_r, busy_r;

   assign free_s   = (state_r == ST_IDLE) || (state_r == ST_CAPTURE);
   assign accept_s = (req0_valid & grant_s[0]) | (req1_valid & grant_s[1]);

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .valid ({req1_valid, req0_valid}),
      .free  (free_s),
      .grant (grant_s)
   );

   // next-state logic; CAPTURE doubles as an accept slot for back-to-back issue
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE:    next_state_s = accept_s ? ST_ISSUE : ST_IDLE;
         ST_ISSUE:   next_state_s = ST_WAIT;
         ST_WAIT:    next_state_s = (cnt_r == CNT_ONE) ? ST_CAPTURE : ST_WAIT;
         ST_CAPTURE: next_state_s = accept_s ? ST_ISSUE : ST_IDLE;
         default:    next_state_s = ST_IDLE;
      endcase
   end

   // state, latency counter and registered control pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         cnt_r        <= '0;
         mul_enable_r <= 1'b0;
         busy_r       <= 1'b0;
         rsp0_valid_r <= 1'b0;
         rsp1_valid_r <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         mul_enable_r <= (next_state_s == ST_ISSUE);
         busy_r       <= (next_state_s != ST_IDLE);
         rsp0_valid_r <= (state_r == ST_CAPTURE) && !owner_r;
         rsp1_valid_r <= (state_r == ST_CAPTURE) &&  owner_r;
         if (state_r == ST_ISSUE) begin
            cnt_r <= CNT_INIT;
         end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r - CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // operand, owner and result registers; operands hold until the next accept
   always_ff @(posedge clk) begin
      if (rst) begin
         mul_a_r    <= '0;
         mul_b_r    <= '0;
         owner_r    <= 1'b0;
         rsp_data_r <= '0;
      end else begin
         if (accept_s) begin
            mul_a_r <= grant_s[1] ? req1_a : req0_a;
            mul_b_r <= grant_s[1] ? req1_b : req0_b;
            owner_r <= grant_s[1];
         end else begin
            mul_a_r <= mul_a_r;
            mul_b_r <= mul_b_r;
            owner_r <= owner_r;
         end
         if (state_r == ST_CAPTURE) begin
            rsp_data_r <= mul_result;
         end else begin
            rsp_data_r <= rsp_data_r;
         end
      end
   end

   assign req0_ready = grant_s[0];
   assign req1_ready = grant_s[1];
   assign mul_enable = mul_enable_r;
   assign mul_a      = mul_a_r;
   assign mul_b      = mul_b_r;
   assign rsp_data   = rsp_data_r;
   assign rsp0_valid = rsp0_valid_r;
   assign rsp1_valid = rsp1_valid_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_mul_arb_ctrl.sv
// Self-checking bench for mul_arb_ctrl with a behavioural GF(2^163) multiplier
// whose result is only valid exactly MUL_LAT cycles after its enable.
module tb_mul_arb_ctrl;
   import mul_arb_ctrl_pkg::*;

   localparam logic [M-1:0] POLY = 163'hC9;
   localparam logic [M-1:0] ZERO = 163'h0;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [M-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp0_valid, rsp1_valid;
   logic [M-1:0] rsp_data;
   logic         mul_enable;
   logic [M-1:0] mul_a, mul_b, mul_result;
   logic         busy;

   mul_arb_ctrl dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
      .mul_enable(mul_enable), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [M-1:0] gfmul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] r, x;
      r = '0;
      x = a;
      for (int i = 0; i < M; i++) begin
         if (b[i]) r = r ^ x;
         x = x[M-1] ? ((x << 1) ^ POLY) : (x << 1);
      end
      return r;
   endfunction

   function automatic logic [M-1:0] rnd();
      logic [191:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[M-1:0];
   endfunction

   // multiplier model: garbage on mul_result except in the enable+3 cycle
   logic [M-1:0] prod_r = '0;
   logic [2:0]   dly_r  = 3'b000;
   always @(posedge clk) begin
      if (mul_enable) prod_r <= gfmul(mul_a, mul_b);
      dly_r <= {dly_r[1:0], mul_enable};
   end
   assign mul_result = dly_r[2] ? prod_r : ~prod_r;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic         owner;
      logic [M-1:0] data;
      int           due;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   grant_q[$];
   int   acc_cyc_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   last_acc = -100;
   logic [M-1:0] acc_a, acc_b;
   logic prev_en = 1'b0;

   task automatic check(input string name, input logic [M-1:0] act, input logic [M-1:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic fail_evt(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: event not allowed here (cycle %0d)", name, cyc);
   endtask

   task automatic record_accept(input int idx, input logic [M-1:0] a, input logic [M-1:0] b);
      sb.push_back('{idx[0], gfmul(a, b), cyc + 5});
      last_acc = cyc;
      acc_a    = a;
      acc_b    = b;
      grant_q.push_back(idx);
      acc_cyc_q.push_back(cyc);
   endtask

   // monitor and scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         check("ready_exclusive", M'(req0_ready & req1_ready), ZERO);
         if (mul_enable) begin
            check("enable_adjacent", M'(prev_en), ZERO);
            check("enable_latency", M'(cyc), M'(last_acc + 1));
            check("mul_a", mul_a, acc_a);
            check("mul_b", mul_b, acc_b);
         end
         if (rsp0_valid || rsp1_valid) begin
            if (rsp0_valid && rsp1_valid) fail_evt("rsp_both");
            if (sb.size() == 0) begin
               fail_evt("rsp_unexpected");
            end else begin
               e = sb.pop_front();
               check("rsp_owner", M'(rsp1_valid), M'(e.owner));
               check("rsp_data", rsp_data, e.data);
               check("rsp_latency", M'(cyc), M'(e.due));
            end
         end
         if (req0_valid && req0_ready) record_accept(0, req0_a, req0_b);
         else if (req1_valid && req1_ready) record_accept(1, req1_a, req1_b);
      end
      prev_en = rst ? 1'b0 : mul_enable;
   end

   task automatic set_req(input int idx, input logic v, input logic [M-1:0] a, input logic [M-1:0] b);
      if (idx == 0) begin
         req0_valid = v; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b;
      end
   endtask

   task automatic wait_accept(input int idx);
      bit got = 1'b0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         got = (idx == 0) ? req0_ready : req1_ready;
      end
      if (!got) fail_evt("accept_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int idx, input logic [M-1:0] a, input logic [M-1:0] b);
      set_req(idx, 1'b1, a, b);
      wait_accept(idx);
      set_req(idx, 1'b0, ZERO, ZERO);
   endtask

   task automatic stream(input int idx, input int n);
      for (int k = 0; k < n; k++) begin
         set_req(idx, 1'b1, rnd(), rnd());
         wait_accept(idx);
      end
      set_req(idx, 1'b0, ZERO, ZERO);
   endtask

   task automatic wait_rsp(input int idx, input logic [M-1:0] expv);
      bit got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         got = (idx == 0) ? rsp0_valid : rsp1_valid;
      end
      if (got) check("vec_data", rsp_data, expv);
      else fail_evt("rsp_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((sb.size() != 0 || busy) && k < 60) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (k == 60) fail_evt("idle_timeout");
   endtask

   typedef struct {
      int           req;
      logic [M-1:0] a;
      logic [M-1:0] b;
      logic [M-1:0] expv;
   } vec_t;

   vec_t vt[4];

   initial begin
      vt[0] = '{0, 163'h2, 163'h3, 163'h6};
      vt[1] = '{1, (163'h1 << 162), 163'h2, 163'hC9};
      vt[2] = '{0, 163'h1, 163'h5DEADBEEFCAFE, 163'h5DEADBEEFCAFE};
      vt[3] = '{1, 163'h3, 163'h3, 163'h5};

      rst = 1'b1;
      set_req(0, 1'b0, ZERO, ZERO);
      set_req(1, 1'b0, ZERO, ZERO);
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", M'(busy), ZERO);
      check("reset_enable", M'(mul_enable), ZERO);
      check("reset_rsp", M'({rsp1_valid, rsp0_valid}), ZERO);
      check("reset_rsp_data", rsp_data, ZERO);
      check("reset_mul_a", mul_a, ZERO);
      check("reset_mul_b", mul_b, ZERO);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         issue(vt[i].req, vt[i].a, vt[i].b);
         wait_rsp(vt[i].req, vt[i].expv);
         wait_idle();
         check("vec_idle_busy", M'(busy), ZERO);
      end

      // both requesters streaming: strict alternation, one accept every 4 cycles
      grant_q.delete();
      acc_cyc_q.delete();
      fork
         stream(0, 4);
         stream(1, 4);
      join
      wait_idle();
      if (grant_q.size() != 8) fail_evt("alt_count");
      for (int i = 0; i < grant_q.size(); i++) check("alt_grant", M'(grant_q[i]), M'(i % 2));
      for (int i = 1; i < acc_cyc_q.size(); i++)
         check("alt_spacing", M'(acc_cyc_q[i] - acc_cyc_q[i-1]), M'(4));

      // reset during WAIT discards the in-flight operation
      issue(0, rnd(), rnd());
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_busy", M'(busy), ZERO);
      check("midrst_enable", M'(mul_enable), ZERO);
      check("midrst_rsp_data", rsp_data, ZERO);
      check("midrst_mul_a", mul_a, ZERO);
      repeat (10) @(posedge clk);
      #1;
      issue(1, 163'h7, 163'h9);
      wait_rsp(1, 163'h3F);
      wait_idle();

      // a valid withdrawn while busy is never granted and leaves the pointer alone
      grant_q.delete();
      issue(0, rnd(), rnd());
      set_req(1, 1'b1, rnd(), rnd());
      @(negedge clk);
      check("withdrawn_ready", M'(req1_ready), ZERO);
      @(posedge clk);
      #1;
      set_req(1, 1'b0, ZERO, ZERO);
      wait_idle();
      fork
         stream(0, 1);
         stream(1, 1);
      join
      wait_idle();
      if (grant_q.size() != 3) fail_evt("withdrawn_count");
      else begin
         check("withdrawn_g0", M'(grant_q[0]), M'(0));
         check("withdrawn_g1", M'(grant_q[1]), M'(1));
         check("withdrawn_g2", M'(grant_q[2]), M'(0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
